// File: rtl/keccak_core_if.sv
// Core-side responder for the 64-bit Keccak streaming interface: loads 25 lanes,
// hands the 1600-bit state to the permutation engine, then streams the result back.
module keccak_core_if #(
  parameter int D_KECCAK_WIDTH = 64,
  parameter int N_LANES        = 25
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic [D_KECCAK_WIDTH-1:0]           din_i,
  input  logic                                din_valid_i,
  input  logic                                last_block_i,
  output logic                                ready_o,
  output logic [D_KECCAK_WIDTH-1:0]           dout_o,
  output logic                                dout_valid_o,
  output logic                                perm_start_o,
  output logic [D_KECCAK_WIDTH*N_LANES-1:0]   perm_state_o,
  input  logic [D_KECCAK_WIDTH*N_LANES-1:0]   perm_state_i,
  input  logic                                perm_done_i
);

  localparam int D_WIDTH = D_KECCAK_WIDTH * N_LANES;
  localparam int CNT_W   = $clog2(N_LANES + 1);
  localparam int IDX_W   = $clog2(D_WIDTH);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_LANES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_PERM  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]                state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [D_WIDTH-1:0]        buf_q;
  logic [D_KECCAK_WIDTH-1:0] dout_q;
  logic                      dout_vld_q;
  logic                      perm_start_q;
  logic                      ready_q;
  logic [IDX_W-1:0]          base;

  // Bit offset of the lane selected by the counter; only used while cnt_q < N_LANES.
  assign base = IDX_W'(cnt_q) * IDX_W'(D_KECCAK_WIDTH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      buf_q        <= '0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      perm_start_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      perm_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Words beyond the last lane (the control unit's trailing zero) are dropped.
          if (din_valid_i && (cnt_q < FULL)) begin
            buf_q[base +: D_KECCAK_WIDTH] <= din_i;
            cnt_q                         <= cnt_q + 1'b1;
          end
          if (last_block_i) begin
            perm_start_q <= 1'b1;
            state_q      <= S_PERM;
          end
        end
        S_PERM: begin
          if (perm_done_i) begin
            buf_q   <= perm_state_i;
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cnt_q == FULL) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            dout_q     <= buf_q[base +: D_KECCAK_WIDTH];
            dout_vld_q <= 1'b1;
            cnt_q      <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_vld_q;
  assign perm_start_o = perm_start_q;
  assign perm_state_o = buf_q;

endmodule

// File: doc/keccak_core_if.md
Name: keccak_core_if

Overview:
Core-side responder for the 64-bit Keccak streaming interface driven by the Keccak control unit.
- Accepts 25 lanes serially after a start pulse and assembles the 1600-bit state.
- Hands the state to the Keccak-f permutation engine through a start/done handshake.
- Streams the permuted state back as 25 consecutive 64-bit words with a valid strobe.

Parameters:
D_KECCAK_WIDTH, 64, lane width in bits (interface word width).
N_LANES, 25, lanes per state; derived D_WIDTH = D_KECCAK_WIDTH*N_LANES (1600).

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  asynchronous, active-high reset.
start_i  in  1  start pulse from control unit.
din_i  in  64  input lane word.
din_valid_i  in  1  din_i valid this cycle.
last_block_i  in  1  end-of-load marker (single-cycle pulse).
ready_o  out  1  high when idle and able to accept start_i.
dout_o  out  64  output lane word.
dout_valid_o  out  1  dout_o valid this cycle.
perm_start_o  out  1  one-cycle pulse launching the permutation.
perm_state_o  out  1600  state presented to the permutation engine.
perm_state_i  in  1600  permuted state from the engine.
perm_done_i  in  1  permutation result valid (one-cycle pulse).

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE, lane counter=0, state buffer=0, dout_o=0, dout_valid_o=0, perm_start_o=0, ready_o=1. Reset mid-operation aborts immediately; no partial output follows.
- All outputs registered. perm_state_o is driven directly by the state buffer.
- Lane k occupies buffer bits [64k+63:64k].
- FSM states: IDLE, LOAD, PERM, DRAIN.
- IDLE:
  - ready_o=1.
  - start_i=1: clear buffer to 0, counter=0, go LOAD.
  - din_valid_i, last_block_i and perm_done_i are ignored.
- LOAD:
  - ready_o=0.
  - Each cycle with din_valid_i=1 and counter<25: write din_i to lane[counter], counter+1.
  - din_valid_i with counter==25: word dropped, no error. The control unit sends a trailing zero word; this is legal.
  - last_block_i=1: assert perm_start_o for exactly one cycle on the next edge, go PERM.
  - Same-cycle din_valid_i and last_block_i: the word is written first; the permutation sees it.
  - last_block_i with counter<25: lanes not written remain 0 (zero padding). Proceed normally.
  - start_i is ignored.
- PERM:
  - perm_state_o is held stable until perm_done_i.
  - perm_done_i=1: capture perm_state_i into the buffer, counter=0, go DRAIN.
  - Inputs other than perm_done_i are ignored. No timeout.
- DRAIN:
  - Beginning the cycle after perm_done_i, dout_valid_o=1 for exactly 25 consecutive cycles.
  - Cycle k (0..24): dout_o = lane k.
  - No backpressure.
  - After lane 24, go IDLE: dout_valid_o=0, dout_o=0, ready_o=1 on the following cycle.
  - start_i during DRAIN is ignored and not queued.
- Latencies:
  - last_block_i to perm_start_o: 1 cycle.
  - perm_done_i to first dout_valid_o: 1 cycle.
  - perm_done_i to ready_o high: 26 cycles.
- dout_o is 0 whenever dout_valid_o=0.

Test Plan:
- Reset: assert rst_i asynchronously between edges -> outputs clear immediately; ready_o=1, dout_valid_o=0, perm_start_o=0, perm_state_o=0.
- Full transaction: start_i, then 25 words with lane k = 0x0101010101010101*k, one trailing zero word, then last_block_i. Engine model returns state XOR all-ones 3 cycles after perm_start_o.
  -> perm_start_o pulses once, 1 cycle after last_block_i.
  -> perm_state_o lanes match inputs; trailing word not stored.
  -> 25 dout words equal ~(0x0101010101010101*k) in order k=0..24.
  -> ready_o=1 on cycle 26 after perm_done_i.
- Short load: start_i, 10 words 0xAAAA..., then last_block_i -> perm_state_o lanes 0..9 = 0xAAAA..., lanes 10..24 = 0.
- Same-cycle: 25th word 0xDEADBEEFCAFEF00D presented together with last_block_i -> lane 24 of perm_state_o = 0xDEADBEEFCAFEF00D at perm_start_o.
- Busy start: pulse start_i during PERM and during DRAIN -> no state change, exactly 25 dout beats, then IDLE.
- Reset mid-DRAIN: assert rst_i after 7 output beats -> dout_valid_o drops at once, FSM=IDLE. A new full transaction afterwards produces correct output.
